// File: rtl/spi_axil_pkg.sv
// Shared types and constants for the SPI IP AXI4-Lite register bank.
package spi_axil_pkg;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ADDR_LSB   = 2;
  localparam int BYTE_LANES = 4;

endpackage

// File: rtl/spi_axil_wr_merge.sv
// Byte-lane merge of a register's current value with write data under WSTRB.
module spi_axil_wr_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_val,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_val;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/spi_axil_regs.sv
// AXI4-Lite responder register bank feeding the SPI core, with per-register write strobes.
// Optional build macro SPI_AXIL_SLVERR_EN: out-of-bank addresses answer SLVERR instead of aliasing.
module spi_axil_regs
  import spi_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    AWADDR,
  input  logic [2:0]                       AWPROT,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]    WDATA,
  input  logic [BYTE_LANES-1:0]            WSTRB,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    ARADDR,
  input  logic [2:0]                       ARPROT,
  input  logic                             ARVALID,
  output logic                             ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]    RDATA,
  output logic [1:0]                       RRESP,
  output logic                             RVALID,
  input  logic                             RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]              reg_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WIDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  logic [DW-1:0] regs [NUM_REGS];

  wr_state_t wr_state, wr_state_nxt;
  logic aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic aw_rdy, aw_rdy_nxt, w_rdy, w_rdy_nxt;
  logic aw_hs, w_hs, commit, wr_err;
  logic [WIDX_W-1:0] aw_widx_q, wr_widx;
  logic [DW-1:0] w_data_q, wr_data, merged;
  logic [BYTE_LANES-1:0] w_strb_q, wr_strb;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0] bresp_q, bresp_nxt;
  logic [NUM_REGS-1:0] pulse_q, pulse_nxt;

  rd_state_t rd_state, rd_state_nxt;
  logic ar_rdy, ar_rdy_nxt, ar_hs, rd_err;
  logic [WIDX_W-1:0] rd_widx;
  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0] rdata_q;
  logic [1:0] rresp_q;

  assign aw_hs = AWVALID && aw_rdy;
  assign w_hs  = WVALID && w_rdy;

  // A channel already latched wins; otherwise the live bus supplies the beat.
  assign wr_widx = aw_done ? aw_widx_q : AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data = w_done ? w_data_q : WDATA;
  assign wr_strb = w_done ? w_strb_q : WSTRB;
  assign wr_idx  = wr_widx[IDX_W-1:0];

  assign ar_hs   = ARVALID && ar_rdy;
  assign rd_widx = ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx  = rd_widx[IDX_W-1:0];

`ifdef SPI_AXIL_SLVERR_EN
  assign wr_err = {1'b0, wr_widx} >= (WIDX_W + 1)'(NUM_REGS);
  assign rd_err = {1'b0, rd_widx} >= (WIDX_W + 1)'(NUM_REGS);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{AWPROT, ARPROT, AWADDR, ARADDR, wr_widx, rd_widx};

  spi_axil_wr_merge #(.DATA_W(DW)) u_merge (
    .old_val (regs[wr_idx]),
    .wdata   (wr_data),
    .wstrb   (wr_strb),
    .merged  (merged)
  );

  always_comb begin
    wr_state_nxt = wr_state;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    aw_rdy_nxt   = 1'b0;
    w_rdy_nxt    = 1'b0;
    bresp_nxt    = bresp_q;
    pulse_nxt    = '0;
    commit       = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        aw_done_nxt = aw_done || aw_hs;
        w_done_nxt  = w_done || w_hs;
        if (aw_done_nxt && w_done_nxt) begin
          commit       = 1'b1;
          wr_state_nxt = WR_RESP;
          aw_done_nxt  = 1'b0;
          w_done_nxt   = 1'b0;
          bresp_nxt    = wr_err ? RESP_SLVERR : RESP_OKAY;
          if (!wr_err) pulse_nxt[wr_idx] = 1'b1;
        end else begin
          aw_rdy_nxt = !aw_done_nxt;
          w_rdy_nxt  = !w_done_nxt;
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          wr_state_nxt = WR_IDLE;
          aw_rdy_nxt   = 1'b1;
          w_rdy_nxt    = 1'b1;
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    ar_rdy_nxt   = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        if (ar_hs) rd_state_nxt = RD_DATA;
        else       ar_rdy_nxt   = 1'b1;
      end
      RD_DATA: begin
        if (RREADY) begin
          rd_state_nxt = RD_IDLE;
          ar_rdy_nxt   = 1'b1;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= WR_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_rdy   <= 1'b0;
      w_rdy    <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rd_state <= RD_IDLE;
      ar_rdy   <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      wr_state <= wr_state_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
      aw_rdy   <= aw_rdy_nxt;
      w_rdy    <= w_rdy_nxt;
      bresp_q  <= bresp_nxt;
      rd_state <= rd_state_nxt;
      ar_rdy   <= ar_rdy_nxt;
      // Capture happens on the AR edge, so a coincident write is not yet visible.
      if (ar_hs) begin
        rdata_q <= rd_err ? '0 : regs[rd_idx];
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_widx_q <= AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    if (w_hs) begin
      w_data_q <= WDATA;
      w_strb_q <= WSTRB;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_nxt;
      if (commit && !wr_err) regs[wr_idx] <= merged;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[DW*i +: DW] = regs[i];
  end

  assign AWREADY      = aw_rdy;
  assign WREADY       = w_rdy;
  assign BVALID       = (wr_state == WR_RESP);
  assign BRESP        = bresp_q;
  assign ARREADY      = ar_rdy;
  assign RVALID       = (rd_state == RD_DATA);
  assign RDATA        = rdata_q;
  assign RRESP        = rresp_q;
  assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_spi_axil_regs.sv
// Randomized self-checking bench for spi_axil_regs against a word-array reference model.
module tb_spi_axil_regs;

  localparam int AW = 5;
  localparam int NR = 4;
`ifdef SPI_AXIL_SLVERR_EN
  localparam bit SLVERR = 1'b1;
`else
  localparam bit SLVERR = 1'b0;
`endif

  logic ACLK, ARESET;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0] AWPROT, ARPROT;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr_pulse;

  spi_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  logic [31:0] model [NR];
  int checks = 0;
  int errors = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_err(input logic [AW-1:0] a);
    return SLVERR && ((int'(a) / 4) >= NR);
  endfunction

  function automatic int m_idx(input logic [AW-1:0] a);
    return (int'(a) / 4) % NR;
  endfunction

  function automatic logic [127:0] m_flat();
    logic [127:0] f = '0;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  task automatic m_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m_err(a)) return;
    for (int b = 0; b < 4; b++)
      if (s[b]) model[m_idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  // Starts and ends at a falling edge.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_ok = 0, w_ok = 0, fa, fw, early = 0, drop_ok = 1, held = 1;
    int cyc = 0;
    logic [NR-1:0] exp_pulse = '0;
    logic [1:0] exp_resp = m_err(addr) ? 2'b10 : 2'b00;
    if (!m_err(addr)) exp_pulse[m_idx(addr)] = 1'b1;
    while (!(aw_ok && w_ok)) begin
      AWVALID = !aw_ok && (cyc >= aw_dly); AWADDR = addr;
      WVALID  = !w_ok && (cyc >= w_dly);   WDATA = data; WSTRB = strb;
      fa = AWVALID && AWREADY;
      fw = WVALID && WREADY;
      @(posedge ACLK);
      @(negedge ACLK);
      aw_ok = aw_ok || fa;
      w_ok  = w_ok || fw;
      if (aw_ok != w_ok) begin
        early = 1;
        drop_ok = drop_ok && (aw_ok ? !AWREADY : !WREADY) && !BVALID;
      end
      cyc++;
      if (cyc > 60) begin
        chk("wr_timeout", {AWREADY, WREADY}, 2'b11);
        AWVALID = 0; WVALID = 0;
        return;
      end
    end
    AWVALID = 0; WVALID = 0;
    m_write(addr, data, strb);
    if (early) chk("wr_ready_drop", drop_ok, 1'b1);
    chk("b_latency", BVALID, 1'b1);
    chk("bresp", BRESP, exp_resp);
    chk("wr_pulse", reg_wr_pulse, exp_pulse);
    chk("wr_regq", reg_q, m_flat());
    for (int i = 0; i < b_dly; i++) begin
      @(negedge ACLK);
      held = held && BVALID && (BRESP == exp_resp) && !AWREADY && !WREADY && (reg_wr_pulse == '0);
    end
    if (b_dly > 0) chk("b_hold", held, 1'b1);
    BREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 0;
    chk("b_done", {BVALID, AWREADY, WREADY, reg_wr_pulse}, {3'b011, {NR{1'b0}}});
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_dly);
    logic [31:0] exp_d = m_err(addr) ? 32'h0 : model[m_idx(addr)];
    logic [1:0] exp_r = m_err(addr) ? 2'b10 : 2'b00;
    logic [31:0] d0;
    bit held = 1;
    int cyc = 0;
    ARVALID = 1; ARADDR = addr;
    while (!ARREADY && cyc < 20) begin
      @(negedge ACLK);
      cyc++;
    end
    if (!ARREADY) begin
      chk("ar_timeout", ARREADY, 1'b1);
      ARVALID = 0;
      return;
    end
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 0;
    chk("r_valid", {RVALID, ARREADY}, 2'b10);
    chk("rdata", RDATA, exp_d);
    chk("rresp", RRESP, exp_r);
    d0 = RDATA;
    for (int i = 0; i < r_dly; i++) begin
      @(negedge ACLK);
      held = held && RVALID && (RDATA == d0) && (RRESP == exp_r) && !ARREADY;
    end
    if (r_dly > 0) chk("r_hold", held, 1'b1);
    RREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 0;
    chk("r_done", {RVALID, ARREADY}, 2'b01);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [31:0] old0;
    ARESET = 1;
    AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(negedge ACLK);
    chk("reset_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, reg_wr_pulse}, '0);
    chk("reset_rdata", RDATA, 32'h0);
    chk("reset_regq", reg_q, '0);
    ARESET = 0;
    repeat (2) @(negedge ACLK);
    chk("idle_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

    for (int i = 0; i < 4; i++) axi_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(AW'(4 * i), 0);
    chk("seq_regq", reg_q, {32'h4, 32'h3, 32'h2, 32'h1});

    axi_write(5'h04, 32'hA5A5_A5A5, 4'hF, 3, 0, 0);
    axi_write(5'h09, 32'h1234_5678, 4'hF, 0, 2, 1);
    axi_write(5'h08, 32'hFFFF_FFFF, 4'b0010, 1, 0, 0);
    chk("strb_merge", reg_q[64 +: 32], 32'h1234_FF78);
    axi_read(5'h0B, 0);
    axi_write(5'h0C, 32'hDEAD_BEEF, 4'h0, 0, 0, 0);
    axi_read(5'h04, 5);
    axi_write(5'h10, 32'hCAFE_0001, 4'hF, 0, 0, 0);
    axi_read(5'h10, 0);
    axi_read(5'h00, 1);

    // Read and write the same register on the same edge.
    old0 = model[0];
    AWVALID = 1; AWADDR = 5'h00; WVALID = 1; WDATA = 32'h5A5A_0F0F; WSTRB = 4'hF;
    ARVALID = 1; ARADDR = 5'h00;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    m_write(5'h00, 32'h5A5A_0F0F, 4'hF);
    chk("rw_same_rdata", RDATA, old0);
    chk("rw_same_valid", {RVALID, BVALID}, 2'b11);
    RREADY = 1; BREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 0; BREADY = 0;
    chk("rw_same_regq", reg_q, m_flat());

    repeat (60) begin
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 3));
    end
    chk("rand_regq", reg_q, m_flat());

    // Reset while a write response is pending.
    AWVALID = 1; AWADDR = 5'h08; WVALID = 1; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    chk("rst_pre_bvalid", BVALID, 1'b1);
    #1 ARESET = 1;
    #1;
    chk("rst_bvalid", {BVALID, AWREADY, WREADY, ARREADY}, 4'b0000);
    chk("rst_regq", reg_q, '0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge ACLK);
    ARESET = 0;
    repeat (2) @(negedge ACLK);
    for (int i = 0; i < NR; i++) axi_read(AW'(4 * i), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
